// File: rtl/alu_mdu_if.sv
// Handshake and data bundle between operand fetch, the execute unit and writeback.
interface alu_mdu_if #(
    parameter int WIDTH = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] opx;
    logic [WIDTH-1:0] opy;
    logic             out_valid;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_hi;
    logic             t;
    logic             t_wr;

    modport master (
        output flush, in_valid, op, opx, opy,
        input  in_ready, out_valid, res, res_hi, t, t_wr
    );

    modport slave (
        input  flush, in_valid, op, opx, opy,
        output in_ready, out_valid, res, res_hi, t, t_wr
    );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage unit: single-cycle integer ops plus iterative unsigned multiply/divide.
// MULU/DIVU run one bit per cycle for WIDTH cycles while in_ready stalls the front end.
module alu_mdu #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    alu_mdu_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     oper_q, oper_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [WIDTH-1:0]     res_hi_q, res_hi_d;
    logic                 t_q, t_d;
    logic                 t_wr_q, t_wr_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic                 multi_cycle;
    logic [SW-1:0]        shamt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_t;
    logic                 alu_t_wr;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   step_acc;

    always_comb begin
        alu_res  = '0;
        alu_t    = 1'b0;
        alu_t_wr = 1'b0;
        shamt    = bus.opy[SW-1:0];
        case (bus.op)
            4'h0: alu_res = bus.opx + bus.opy;
            4'h1: alu_res = bus.opx - bus.opy;
            4'h2: alu_res = bus.opx & bus.opy;
            4'h3: alu_res = bus.opx | bus.opy;
            4'h4: alu_res = bus.opx << shamt;
            4'h5: alu_res = bus.opx >> shamt;
            4'h6: alu_res = WIDTH'($signed(bus.opx) >>> shamt);
            4'h7: begin
                alu_t    = ($signed(bus.opx) < $signed(bus.opy));
                alu_t_wr = 1'b1;
                alu_res  = WIDTH'(alu_t);
            end
            4'h8: begin
                alu_t    = (bus.opx < bus.opy);
                alu_t_wr = 1'b1;
                alu_res  = WIDTH'(alu_t);
            end
            4'h9: begin
                alu_t    = (bus.opx != bus.opy);
                alu_t_wr = 1'b1;
                alu_res  = WIDTH'(alu_t);
            end
            4'hA, 4'hB: alu_res = '0;
            default: alu_res = bus.opx;
        endcase
    end

    // acc holds {partial product, multiplier} for MULU and {remainder, dividend/quotient} for DIVU
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, oper_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, oper_q};
        if (is_div_q) begin
            if (div_diff[WIDTH]) begin
                step_acc = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_acc = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        accept      = bus.in_valid && (state_q == IDLE) && !bus.flush;
        multi_cycle = (bus.op == 4'hA) || ((bus.op == 4'hB) && (bus.opy != '0));
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        oper_d      = oper_q;
        acc_d       = acc_q;
        res_d       = res_q;
        res_hi_d    = res_hi_q;
        t_d         = t_q;
        t_wr_d      = t_wr_q;
        out_valid_d = 1'b0;

        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && multi_cycle) begin
                        state_d  = RUN;
                        cnt_d    = SW'(WIDTH - 1);
                        is_div_d = (bus.op == 4'hB);
                        oper_d   = bus.opy;
                        acc_d    = {{WIDTH{1'b0}}, bus.opx};
                    end else if (accept) begin
                        // DIVU by zero lands here and completes immediately
                        out_valid_d = 1'b1;
                        res_d       = (bus.op == 4'hB) ? '1 : alu_res;
                        res_hi_d    = (bus.op == 4'hB) ? bus.opx : '0;
                        t_d         = alu_t;
                        t_wr_d      = alu_t_wr;
                    end
                end
                RUN: begin
                    acc_d = step_acc;
                    if (cnt_q == '0) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b1;
                        res_d       = step_acc[WIDTH-1:0];
                        res_hi_d    = step_acc[2*WIDTH-1:WIDTH];
                        t_d         = 1'b0;
                        t_wr_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_q - SW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            oper_q      <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            res_hi_q    <= '0;
            t_q         <= 1'b0;
            t_wr_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            oper_q      <= oper_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            res_hi_q    <= res_hi_d;
            t_q         <= t_d;
            t_wr_q      <= t_wr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.res_hi    = res_hi_q;
    assign bus.t         = t_q;
    assign bus.t_wr      = t_wr_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu at WIDTH=16 and WIDTH=32: stimulus pushes expected
// responses, per-instance monitors pop and compare on every out_valid pulse.
module tb_alu_mdu;
    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] res_hi;
        logic        t;
        logic        t_wr;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   n_low;
    exp_t q16[$];
    exp_t q32[$];

    alu_mdu_if #(.WIDTH(16)) bus16 ();
    alu_mdu_if #(.WIDTH(32)) bus32 ();

    alu_mdu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after accept edge k it reads k, so latency is counted in edges
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [3:0] op,
                                 input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] e_res, input logic [15:0] e_hi,
                                 input logic e_t, input logic e_twr,
                                 input int edges, input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (bus16.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput({name, ".ready_wait"}, 32'(bus16.in_ready), 32'd1);
        bus16.op       = op;
        bus16.opx      = x;
        bus16.opy      = y;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        if (push) begin
            e.name   = name;
            e.res    = 32'(e_res);
            e.res_hi = 32'(e_hi);
            e.t      = e_t;
            e.t_wr   = e_twr;
            e.cyc    = cyc + edges;
            q16.push_back(e);
        end
    endtask

    task automatic applyStimulus32(input string name, input logic [3:0] op,
                                   input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] e_res, input logic [31:0] e_hi,
                                   input int edges);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (bus32.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput({name, ".ready_wait"}, 32'(bus32.in_ready), 32'd1);
        bus32.op       = op;
        bus32.opx      = x;
        bus32.opy      = y;
        bus32.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        e.name   = name;
        e.res    = e_res;
        e.res_hi = e_hi;
        e.t      = 1'b0;
        e.t_wr   = 1'b0;
        e.cyc    = cyc + edges;
        q32.push_back(e);
    endtask

    always @(negedge clk) begin : mon16
        exp_t e;
        if (bus16.out_valid === 1'b1) begin
            checkOutput("w16.expected_pulse", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                checkOutput({e.name, ".res"},    32'(bus16.res),    e.res);
                checkOutput({e.name, ".res_hi"}, 32'(bus16.res_hi), e.res_hi);
                checkOutput({e.name, ".t"},      32'(bus16.t),      32'(e.t));
                checkOutput({e.name, ".t_wr"},   32'(bus16.t_wr),   32'(e.t_wr));
                checkOutput({e.name, ".edge"},   32'(cyc),          32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon32
        exp_t e;
        if (bus32.out_valid === 1'b1) begin
            checkOutput("w32.expected_pulse", 32'(q32.size() != 0), 32'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                checkOutput({e.name, ".res"},    bus32.res,         e.res);
                checkOutput({e.name, ".res_hi"}, bus32.res_hi,      e.res_hi);
                checkOutput({e.name, ".t_wr"},   32'(bus32.t_wr),   32'(e.t_wr));
                checkOutput({e.name, ".edge"},   32'(cyc),          32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        bus16.flush    = 1'b0;
        bus16.in_valid = 1'b0;
        bus16.op       = '0;
        bus16.opx      = '0;
        bus16.opy      = '0;
        bus32.flush    = 1'b0;
        bus32.in_valid = 1'b0;
        bus32.op       = '0;
        bus32.opx      = '0;
        bus32.opy      = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.in_ready",  32'(bus16.in_ready),  32'd1);
        checkOutput("reset.out_valid", 32'(bus16.out_valid), 32'd0);
        checkOutput("reset.res",       32'(bus16.res),       32'd0);
        checkOutput("reset.res_hi",    32'(bus16.res_hi),    32'd0);
        checkOutput("reset.t_wr",      32'(bus16.t_wr),      32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus("add_ovf",  4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus("sub_wrap", 4'h1, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus("sra",      4'h6, 16'h8000, 16'h0013, 16'hF000, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus("slt",      4'h7, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1, 0, 1'b1);
        applyStimulus("sltu",     4'h8, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 1'b1);
        applyStimulus("cmp_eq",   4'h9, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 1'b1);
        applyStimulus("cmp_ne",   4'h9, 16'h0005, 16'h0006, 16'h0001, 16'h0000, 1'b1, 1'b1, 0, 1'b1);
        applyStimulus("and",      4'h2, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus("or",       4'h3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus("sll",      4'h4, 16'h0001, 16'h000F, 16'h8000, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus("srl",      4'h5, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus("move_c",   4'hC, 16'h1234, 16'hFFFF, 16'h1234, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus("move_f",   4'hF, 16'hBEEF, 16'h0001, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b1);

        applyStimulus("mulu_max", 4'hA, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 16, 1'b1);
        n_low = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus16.in_ready === 1'b0) n_low++;
            @(posedge clk);
            #1;
        end
        checkOutput("mulu_max.busy_cycles", 32'(n_low), 32'd16);
        checkOutput("mulu_max.ready_after", 32'(bus16.in_ready), 32'd1);

        applyStimulus("divu_100_7",  4'hB, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 16, 1'b1);
        applyStimulus("divu_by_0",   4'hB, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 0,  1'b1);
        applyStimulus("mulu_3_5",    4'hA, 16'd3,    16'd5,    16'd15,   16'd0,    1'b0, 1'b0, 16, 1'b1);
        applyStimulus("divu_ffff_10",4'hB, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, 1'b0, 16, 1'b1);

        // Flush five edges into a MULU while a new op is offered on the same edge
        applyStimulus("mulu_flushed", 4'hA, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b0, 16, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus16.flush    = 1'b1;
        bus16.in_valid = 1'b1;
        bus16.op       = 4'h0;
        bus16.opx      = 16'h0001;
        bus16.opy      = 16'h0001;
        @(posedge clk);
        #1;
        bus16.flush    = 1'b0;
        bus16.in_valid = 1'b0;
        checkOutput("flush.in_ready",    32'(bus16.in_ready),  32'd1);
        checkOutput("flush.out_valid",   32'(bus16.out_valid), 32'd0);
        checkOutput("flush.res_hold",    32'(bus16.res),       32'h0FFF);
        checkOutput("flush.res_hi_hold", 32'(bus16.res_hi),    32'h000F);
        repeat (18) @(posedge clk);
        applyStimulus("add_after_flush", 4'h0, 16'd2, 16'd3, 16'd5, 16'd0, 1'b0, 1'b0, 0, 1'b1);

        // Asynchronous reset in the middle of a DIVU
        applyStimulus("slt_pre_rst", 4'h7, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1, 0, 1'b1);
        applyStimulus("divu_killed", 4'hB, 16'd100, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0, 16, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid.res",       32'(bus16.res),       32'd0);
        checkOutput("rst_mid.res_hi",    32'(bus16.res_hi),    32'd0);
        checkOutput("rst_mid.t",         32'(bus16.t),         32'd0);
        checkOutput("rst_mid.t_wr",      32'(bus16.t_wr),      32'd0);
        checkOutput("rst_mid.out_valid", 32'(bus16.out_valid), 32'd0);
        checkOutput("rst_mid.in_ready",  32'(bus16.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_release.in_ready", 32'(bus16.in_ready), 32'd1);
        applyStimulus("mulu_after_rst", 4'hA, 16'd3, 16'd5, 16'd15, 16'd0, 1'b0, 1'b0, 16, 1'b1);

        applyStimulus32("w32.mulu_max", 4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        32'h0000_0001, 32'hFFFF_FFFE, 32);
        n_low = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus32.in_ready === 1'b0) n_low++;
            @(posedge clk);
            #1;
        end
        checkOutput("w32.mulu_max.busy_cycles", 32'(n_low), 32'd32);
        applyStimulus32("w32.divu", 4'hB, 32'd1000000, 32'd3, 32'h0005_1615, 32'd1, 32);
        applyStimulus32("w32.add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 32'd0, 0);

        for (int i = 0; i < 100 && (q16.size() != 0 || q32.size() != 0); i++) @(posedge clk);
        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(q16.size() + q32.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage unit for the 16-bit pipelined CPU, replacing the fixed-width single-cycle ALU. Performs single-cycle integer ops at one result per cycle, plus iterative unsigned multiply and divide taking WIDTH cycles each. The unit sits between the operand-fetch registers and the memory/writeback stage. A valid/ready handshake lets the hazard unit stall the front end while a multi-cycle op runs.

## Interface
- WIDTH, 16, datapath width; power of two, ≥ 8
- SW = $clog2(WIDTH), derived localparam; shift-amount width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort of the in-flight op; branch mispredict or exception
- in_valid  in  1  op, opx and opy are valid this cycle
- in_ready  out  1  high when state is IDLE; combinational from state
- op  in  4  operation select
- opx, opy  in  WIDTH  operands; the decoder has already folded immediates into opy
- out_valid  out  1  one-cycle pulse; res, res_hi, t and t_wr are valid
- res  out  WIDTH  primary result
- res_hi  out  WIDTH  MULU high half or DIVU remainder; 0 for other ops
- t  out  1  T-flag value
- t_wr  out  1  active-high T-flag write enable, qualified by out_valid

## Operation
- Accept: in_valid && in_ready && !flush, sampled at the rising edge.
- op encoding:
  - 0 ADD: opx+opy, wrapping mod 2^WIDTH
  - 1 SUB: opx−opy, wrapping mod 2^WIDTH
  - 2 AND
  - 3 OR
  - 4 SLL: shift by opy[SW-1:0]
  - 5 SRL: logical shift by opy[SW-1:0]
  - 6 SRA: arithmetic shift by opy[SW-1:0]
  - 7 SLT: t = signed opx < signed opy
  - 8 SLTU: t = unsigned opx < unsigned opy
  - 9 CMP: t = (opx != opy)
  - A MULU
  - B DIVU
  - C–F MOVE: res = opx
- For ops 7–9: t_wr=1 and res = {WIDTH-1 zeros, t}. For all other ops: t_wr=0, t=0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - Single-cycle ops: result is registered at the accept edge, out_valid is set, and the FSM stays in IDLE. Back-to-back accepts are allowed.
  - MULU/DIVU: operands are latched, cnt=WIDTH−1, and the FSM enters RUN. out_valid is set to 0.
  - DIVU with opy=0: treated as a single-cycle op. res = all ones, res_hi = opx, t_wr=0.
- RUN:
  - MULU uses a shift-add, one bit per cycle, with a 2·WIDTH-bit accumulator.
  - DIVU uses restoring division, one quotient bit per cycle.
  - On the edge where cnt==0: results are registered, out_valid=1, and the FSM returns to IDLE. Otherwise cnt decrements.
- flush:
  - In any state, flush forces IDLE and out_valid=0 at the next edge.
  - The partial result is discarded, and res/res_hi hold their previous values.
  - A simultaneous in_valid is not accepted.
- out_valid is a pulse. It clears on the next edge unless a new single-cycle op is accepted on that edge.
- Reset, asynchronous, including mid-op:
  - state=IDLE, cnt=0
  - res=0, res_hi=0, t=0, t_wr=0, out_valid=0
  - in_ready=1 as soon as rst deasserts

## Timing
- Single-cycle op accepted at edge k: out_valid high during cycle k→k+1. Latency is 1 and throughput is 1 per cycle.
- MULU/DIVU accepted at edge k: in_ready is low from k until edge k+WIDTH. out_valid is high for the cycle following edge k+WIDTH.
- in_ready returns high in that same cycle, so a new op can be accepted at edge k+WIDTH+1.
- No combinational path from in_valid or op to any output. in_ready depends on state only.
- Multiply carry chain is WIDTH+1 bits. Divide partial remainder is WIDTH+1 bits. Neither exceeds one adder per cycle.

## Test plan
- WIDTH=16, back-to-back ADD 0x7FFF+0x0001 then SUB 0x0000−0x0001 → res 0x8000, then 0xFFFF, on consecutive out_valid cycles with t_wr=0.
- SRA 0x8000 by opy=0x0013 (uses low 4 bits = 3) → res 0xF000. SLT 0xFFFF vs 0x0001 → t=1, t_wr=1, res 0x0001. SLTU with the same operands → t=0.
- MULU 0xFFFF×0xFFFF → res 0x0001, res_hi 0xFFFE. out_valid exactly 16 edges after accept, in_ready low for the intervening 16 cycles.
- DIVU 100/7 → res 14, res_hi 2 after 16 cycles. DIVU 0x1234/0 → res 0xFFFF, res_hi 0x1234, out_valid after 1 cycle.
- flush asserted 5 cycles into a MULU while in_valid=1 → no out_valid pulse, in_ready high the next cycle, and a following ADD completes normally.
- rst low mid-DIVU → all outputs 0 immediately, in_ready=1. After release, the next op completes with correct latency. Repeat for WIDTH=32 with a MULU of 0xFFFFFFFF² and a 32-cycle latency check.
